// File: rtl/bufg_gt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bufg_gt_pkg
//  Description : Shared constants, state encoding and helpers for the
//                BUFG_GT sequencing logic and its BUFG_GT-side wrappers.
//                Contents: default depths/timings, FSM state encoding,
//                counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package bufg_gt_pkg;

   // Parameter defaults
   localparam int unsigned c_SYNC_STAGES_DEF = 2;
   localparam int unsigned c_CLR_HOLD_DEF    = 4;
   localparam int unsigned c_CE_SETTLE_DEF   = 2;

   // State encoding
   localparam logic [1:0] c_ST_CLEAR  = 2'b00;
   localparam logic [1:0] c_ST_SETTLE = 2'b01;
   localparam logic [1:0] c_ST_RUN    = 2'b10;

   typedef enum logic [1:0] {
      ST_CLEAR  = c_ST_CLEAR,
      ST_SETTLE = c_ST_SETTLE,
      ST_RUN    = c_ST_RUN
   } sync_state_e;

   // Width of a counter that must hold values up to max(a, b) inclusive.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage : bufg_gt_pkg
`default_nettype wire

// File: rtl/bufg_gt_sync_sync_bit.sv
`default_nettype none
// ============================================================================
//  Module      : sync_bit
//  Description : Multi-flop synchronizer for one asynchronous bit.
//  Ports       : CLK  - destination clock
//                RST  - synchronous active-high clear of the chain
//                D    - asynchronous input bit
//                Q    - synchronized output (last flop of the chain)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_bit #(
   parameter int unsigned STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic D,
   output logic Q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], D};
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign Q = sync_q[STAGES-1];

endmodule : sync_bit
`default_nettype wire

// File: rtl/bufg_gt_sync.sv
`default_nettype none
// ============================================================================
//  Module      : bufg_gt_sync
//  Description : Sequences CE/CLR/DIV for a downstream BUFG_GT. Any clear
//                request or divide-code change forces a CLEAR (CLRSYNC high
//                for at least CLR_HOLD cycles), then a SETTLE window with CE
//                held low, then RUN where CE passes through synchronized.
//  Ports       : CLK     - clock
//                RST     - synchronous active-high reset
//                CE      - async clock-enable request
//                CLR     - async clear request (active-high)
//                DIV_IN  - requested divide code (quasi-static, sync to CLK)
//                CESYNC  - registered CE for BUFG_GT
//                CLRSYNC - registered clear for BUFG_GT
//                DIV_OUT - applied divide code for BUFG_GT
//                BUSY    - high whenever not in RUN
//  Revision    : 1.0 - initial release
// ============================================================================
module bufg_gt_sync
   import bufg_gt_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = c_SYNC_STAGES_DEF,  // 2..4
   parameter int unsigned CLR_HOLD    = c_CLR_HOLD_DEF,     // >= 1
   parameter int unsigned CE_SETTLE   = c_CE_SETTLE_DEF     // >= 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CE,
   input  logic       CLR,
   input  logic [2:0] DIV_IN,
   output logic       CESYNC,
   output logic       CLRSYNC,
   output logic [2:0] DIV_OUT,
   output logic       BUSY
);

   localparam int unsigned      CNT_W         = cnt_width(CLR_HOLD, CE_SETTLE);
   localparam logic [CNT_W-1:0] c_HOLD_MAX    = CNT_W'(CLR_HOLD);
   localparam logic [CNT_W-1:0] c_HOLD_LAST   = CNT_W'(CLR_HOLD - 1);
   localparam logic [CNT_W-1:0] c_SETTLE_LAST = CNT_W'(CE_SETTLE - 1);

   logic ce_s;
   logic clr_s;

   sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ce (
      .CLK (CLK),
      .RST (RST),
      .D   (CE),
      .Q   (ce_s)
   );

   sync_bit #(.STAGES(SYNC_STAGES)) u_sync_clr (
      .CLK (CLK),
      .RST (RST),
      .D   (CLR),
      .Q   (clr_s)
   );

   sync_state_e      state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [2:0]       div_out_q, div_out_d;
   logic             cesync_q,  cesync_d;
   logic             clrsync_q, clrsync_d;
   logic             busy_q,    busy_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_out_d = div_out_q;

      case (state_q)
         ST_CLEAR: begin
            // Counter saturates so a long CLR hold cannot wrap it.
            if (cnt_q != c_HOLD_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            // Leave once the minimum hold is met and no clear is pending;
            // the divide code is latched only here.
            if ((cnt_q >= c_HOLD_LAST) && !clr_s) begin
               state_d   = ST_SETTLE;
               cnt_d     = '0;
               div_out_d = DIV_IN;
            end
         end
         ST_SETTLE: begin
            if (clr_s) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end else if (cnt_q >= c_SETTLE_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RUN: begin
            // Clear request and divide change share one path: a single
            // CLEAR entry whichever fires.
            if (clr_s || (DIV_IN != div_out_q)) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
         end
      endcase

      // Outputs follow the next state so they change on the transition edge.
      clrsync_d = (state_d == ST_CLEAR);
      busy_d    = (state_d != ST_RUN);
      // CE passes only while remaining in RUN; the entry edge keeps it low.
      cesync_d  = (state_q == ST_RUN) && (state_d == ST_RUN) && ce_s;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_CLEAR;
         cnt_q     <= '0;
         div_out_q <= 3'b000;
         cesync_q  <= 1'b0;
         clrsync_q <= 1'b1;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_out_q <= div_out_d;
         cesync_q  <= cesync_d;
         clrsync_q <= clrsync_d;
         busy_q    <= busy_d;
      end
   end

   assign CESYNC  = cesync_q;
   assign CLRSYNC = clrsync_q;
   assign DIV_OUT = div_out_q;
   assign BUSY    = busy_q;

endmodule : bufg_gt_sync
`default_nettype wire

// File: tb/tb_bufg_gt_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bufg_gt_sync
//  Description : Self-checking bench for bufg_gt_sync: directed timing
//                tables plus randomized CE/CLR/DIV/RST traffic compared
//                every cycle against a timestamp-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bufg_gt_sync;

   localparam int SS = 2;
   localparam int CH = 4;
   localparam int CS = 2;

   logic       CLK = 1'b0;
   logic       RST;
   logic       CE;
   logic       CLR;
   logic [2:0] DIV_IN;
   logic       CESYNC;
   logic       CLRSYNC;
   logic [2:0] DIV_OUT;
   logic       BUSY;

   always #5 CLK = ~CLK;

   bufg_gt_sync #(
      .SYNC_STAGES (SS),
      .CLR_HOLD    (CH),
      .CE_SETTLE   (CS)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .CE      (CE),
      .CLR     (CLR),
      .DIV_IN  (DIV_IN),
      .CESYNC  (CESYNC),
      .CLRSYNC (CLRSYNC),
      .DIV_OUT (DIV_OUT),
      .BUSY    (BUSY)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model: phase (0=clear,1=settle,2=run) plus the edge index at
   // which the phase was entered; synchronizers are plain delay lines.
   // ---------------------------------------------------------------------
   int         m_mode = 0;
   int         m_n    = 0;
   int         m_tent = 0;
   logic       m_ces  = 1'b0;
   logic [2:0] m_div  = 3'b000;
   bit         ce_h  [SS];
   bit         clr_h [SS];

   task automatic model_step();
      bit ce_s, clr_s;
      m_n++;
      if (RST) begin
         m_mode = 0;
         m_tent = m_n;
         m_ces  = 1'b0;
         m_div  = 3'b000;
         for (int i = 0; i < SS; i++) begin
            ce_h[i]  = 1'b0;
            clr_h[i] = 1'b0;
         end
      end else begin
         ce_s  = ce_h[SS-1];
         clr_s = clr_h[SS-1];
         for (int i = SS - 1; i > 0; i--) begin
            ce_h[i]  = ce_h[i-1];
            clr_h[i] = clr_h[i-1];
         end
         ce_h[0]  = (CE === 1'b1);
         clr_h[0] = (CLR === 1'b1);
         m_ces = 1'b0;
         case (m_mode)
            0: if ((m_n - m_tent >= CH) && !clr_s) begin
                  m_mode = 1;
                  m_tent = m_n;
                  m_div  = DIV_IN;
               end
            1: if (clr_s) begin
                  m_mode = 0;
                  m_tent = m_n;
               end else if (m_n - m_tent >= CS) begin
                  m_mode = 2;
               end
            default: if (clr_s || (DIV_IN != m_div)) begin
                  m_mode = 0;
                  m_tent = m_n;
               end else begin
                  m_ces = ce_s;
               end
         endcase
      end
   endtask

   always @(posedge CLK) begin
      model_step();
      #1;
      chk("m_cesync",  CESYNC,  m_ces);
      chk("m_clrsync", CLRSYNC, m_mode == 0);
      chk("m_busy",    BUSY,    m_mode != 2);
      chk("m_div_out", DIV_OUT, m_div);
   end

   // Sample point: 1 time unit after the rising edge. Drive at +2.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Reset for n cycles (checking reset values), release, check startup.
   task automatic reset_and_startup(input int n);
      RST = 1'b1; CE = 1'b1; CLR = 1'b0; DIV_IN = 3'd3;
      for (int i = 0; i < n; i++) begin
         tick();
         chk("rst_cesync",  CESYNC,  0);
         chk("rst_clrsync", CLRSYNC, 1);
         chk("rst_div",     DIV_OUT, 0);
         chk("rst_busy",    BUSY,    1);
         #1;
      end
      RST = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         tick();
         chk("up_clrsync", CLRSYNC, (e < 4) ? 1 : 0);
         chk("up_div",     DIV_OUT, (e < 4) ? 0 : 3);
         chk("up_busy",    BUSY,    (e < 6) ? 1 : 0);
         chk("up_cesync",  CESYNC,  (e >= 7) ? 1 : 0);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int clr_left;
      RST = 1'b1; CE = 1'b1; CLR = 1'b0; DIV_IN = 3'd3;

      // Startup after power-on reset
      reset_and_startup(3);

      // CE toggle in RUN: 3-edge latency each way
      CE = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         tick();
         chk("ce_fall", CESYNC, (e < 3) ? 1 : 0);
         chk("ce_fall_clr", CLRSYNC, 0);
         #1;
      end
      CE = 1'b1;
      for (int e = 1; e <= 3; e++) begin
         tick();
         chk("ce_rise", CESYNC, (e < 3) ? 0 : 1);
         chk("ce_rise_clr", CLRSYNC, 0);
         #1;
      end

      // Divide change 3->5 in RUN
      DIV_IN = 3'd5;
      for (int e = 1; e <= 8; e++) begin
         tick();
         chk("div_clrsync", CLRSYNC, (e < 5) ? 1 : 0);
         chk("div_busy",    BUSY,    (e < 7) ? 1 : 0);
         chk("div_out",     DIV_OUT, (e < 5) ? 3 : 5);
         chk("div_cesync",  CESYNC,  (e >= 8) ? 1 : 0);
         #1;
      end

      // Single-cycle CLR pulse in RUN
      CLR = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         tick();
         chk("pls_clrsync", CLRSYNC, (e >= 3 && e <= 6) ? 1 : 0);
         chk("pls_busy",    BUSY,    (e >= 3 && e < 9) ? 1 : 0);
         chk("pls_cesync",  CESYNC,  (e < 3 || e >= 10) ? 1 : 0);
         #1;
         if (e == 1) CLR = 1'b0;
      end

      // CLR held 20 cycles with a divide change inside the clear
      CLR = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (e >= 3) chk("hold_clrsync", CLRSYNC, 1);
         #1;
         if (e == 10) DIV_IN = 3'd6;
      end
      // Release, then a one-cycle re-pulse that lands during SETTLE
      CLR = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         chk("rel_clrsync", CLRSYNC, (e != 3 && e < 8) ? 1 : 0);
         if (e == 3) chk("rel_div", DIV_OUT, 6);
         #1;
         if (e == 1) CLR = 1'b1;
         if (e == 2) CLR = 1'b0;
      end
      repeat (4) begin tick(); #1; end

      // One-cycle reset in RUN, startup timing repeats
      chk("run_busy", BUSY, 0);
      reset_and_startup(1);

      // Randomized traffic
      clr_left = 0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         #1;
         RST = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 9) == 0) CE = ~CE;
         if (clr_left == 0 && $urandom_range(0, 59) == 0)
            clr_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 25)) : 1;
         CLR = (clr_left != 0);
         if (clr_left != 0) clr_left--;
         if ($urandom_range(0, 79) == 0) DIV_IN = 3'($urandom_range(0, 7));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_bufg_gt_sync
`default_nettype wire
